// File: rtl/rule_packer_pkg.sv
// rtl/rule_packer_pkg.sv - shared constants, types and helpers for the rule packer
package rule_packer_pkg;

    localparam int PACK_LANES   = 8;
    localparam int ID_W         = 16;
    localparam int BEAT_W       = PACK_LANES * ID_W;

    typedef logic [ID_W-1:0] rule_id_t;

    // One output FIFO entry: framing bits on top, packed IDs below (slot 0 in [15:0])
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [5:0]        empty;
        logic [BEAT_W-1:0] data;
    } packed_beat_t;

    localparam int BEAT_ENTRY_W = $bits(packed_beat_t);

    // Unused bytes in a beat that carries k valid IDs (k = 0..8)
    function automatic logic [5:0] empty_bytes(input logic [3:0] k);
        return 6'd16 - {1'b0, k, 1'b0};
    endfunction

endpackage

// File: rtl/push2_fifo.sv
// rtl/push2_fifo.sv - register FIFO with two-wide push, one-wide show-ahead pop
module push2_fifo #(
    parameter int WIDTH = 136,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push0,
    input  logic [WIDTH-1:0]       i_data0,
    input  logic                   i_push1,
    input  logic [WIDTH-1:0]       i_data1,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   ONE_C  = 1;
    localparam logic [AW:0]   TWO_C  = 2;
    localparam logic [AW-1:0] STEP_C = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_pop;
    logic [AW:0]      w_push_n;
    logic [AW-1:0]    w_wr_ptr1;

    // i_push1 is only ever raised together with i_push0; the caller never overfills
    assign w_pop     = i_pop && (r_count != '0);
    assign w_push_n  = i_push1 ? TWO_C : (i_push0 ? ONE_C : '0);
    assign w_wr_ptr1 = r_wr_ptr + STEP_C;

    // Storage write: second push lands right behind the first
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_data0;
        if (i_push1) r_mem[w_wr_ptr1] <= i_data1;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_n[AW-1:0];
            r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, w_pop};
            r_count  <= r_count + w_push_n - {{AW{1'b0}}, w_pop};
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/rule_packer.sv
// rtl/rule_packer.sv - packs non-zero rule IDs into framed 128-bit beats; optional RULE_PACKER_DEDUP_EN
module rule_packer
    import rule_packer_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int LANE_W     = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_LEVEL   = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_match_valid,
    input  logic                        in_match_eop,
    input  logic [NUM_LANES*LANE_W-1:0] in_match_data,
    output logic                        in_almost_full,
    output logic                        out_match_valid,
    input  logic                        out_match_ready,
    output logic                        out_match_sop,
    output logic                        out_match_eop,
    output logic [NUM_LANES*LANE_W-1:0] out_match_data,
    output logic [5:0]                  out_match_empty,
    output logic [31:0]                 rule_cnt,
    output logic [31:0]                 drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] AF_LVL  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

    // Stage 1 signals
    logic [PACK_LANES-1:0] w_mask;
    logic [2:0]            w_pos [PACK_LANES];
    logic [3:0]            w_n;
    logic                  r_s1_valid;
    logic                  r_s1_eop;
    logic [PACK_LANES-1:0] r_s1_mask;
    logic [2:0]            r_s1_pos [PACK_LANES];
    logic [3:0]            r_s1_n;
    logic [BEAT_W-1:0]     r_s1_data;

    // Stage 2 signals
    logic [BEAT_W-1:0]     r_acc;
    logic [2:0]            r_h;
    logic                  r_first;
    logic [PACK_LANES-1:0] w_m2;
    logic [2:0]            w_p2 [PACK_LANES];
    logic [3:0]            w_n2;
    logic [3:0]            w_dst [PACK_LANES];
    logic [3:0]            w_t;
    logic [2*BEAT_W-1:0]   w_slots;
    logic [1:0]            w_push_cnt;
    packed_beat_t          w_beat0;
    packed_beat_t          w_beat1;
    logic [3:0]            w_ids;
    logic [2:0]            w_h_nxt;
    logic [BEAT_W-1:0]     w_acc_nxt;
    logic                  w_first_nxt;

    // Push register stage and FIFO signals
    logic [1:0]            r_push_cnt;
    packed_beat_t          r_beat0;
    packed_beat_t          r_beat1;
    logic [3:0]            r_push_ids;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic                  w_drop;
    logic                  w_push0;
    logic                  w_push1;
    packed_beat_t          w_head;

`ifdef RULE_PACKER_DEDUP_EN
    rule_id_t              r_last_id;
    rule_id_t              w_last_nxt;
`endif

    // Stage 1: lane-valid mask, popcount and per-lane prefix position
    always_comb begin
        w_mask = '0;
        w_n    = '0;
        for (int i = 0; i < PACK_LANES; i++) begin
            w_mask[i] = (in_match_data[i*ID_W +: ID_W] != '0);
`ifdef RULE_PACKER_DEDUP_EN
            for (int j = 0; j < i; j++) begin
                if (in_match_data[j*ID_W +: ID_W] == in_match_data[i*ID_W +: ID_W])
                    w_mask[i] = 1'b0;
            end
`endif
        end
        for (int i = 0; i < PACK_LANES; i++) begin
            w_pos[i] = w_n[2:0];
            w_n      = w_n + {3'b000, w_mask[i]};
        end
    end

    // Stage 1 capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_n     <= '0;
            r_s1_data  <= '0;
            for (int i = 0; i < PACK_LANES; i++) r_s1_pos[i] <= '0;
        end else begin
            r_s1_valid <= in_match_valid;
            r_s1_eop   <= in_match_valid & in_match_eop;
            r_s1_mask  <= w_mask;
            r_s1_n     <= w_n;
            r_s1_data  <= in_match_data;
            for (int i = 0; i < PACK_LANES; i++) r_s1_pos[i] <= w_pos[i];
        end
    end

    // Stage 2 placement: held IDs first, then incoming IDs in lane order
    always_comb begin
        w_m2 = r_s1_mask;
        w_n2 = r_s1_n;
        for (int i = 0; i < PACK_LANES; i++) w_p2[i] = r_s1_pos[i];
`ifdef RULE_PACKER_DEDUP_EN
        w_n2 = '0;
        for (int i = 0; i < PACK_LANES; i++) begin
            if (r_s1_data[i*ID_W +: ID_W] == r_last_id) w_m2[i] = 1'b0;
            w_p2[i] = w_n2[2:0];
            w_n2    = w_n2 + {3'b000, w_m2[i]};
        end
`endif
        w_t     = {1'b0, r_h} + w_n2;
        w_slots = '0;
        for (int j = 0; j < PACK_LANES; j++) begin
            if (j < int'(r_h)) w_slots[j*ID_W +: ID_W] = r_acc[j*ID_W +: ID_W];
        end
        for (int i = 0; i < PACK_LANES; i++) begin
            w_dst[i] = {1'b0, r_h} + {1'b0, w_p2[i]};
            if (w_m2[i]) w_slots[{w_dst[i], 4'b0000} +: ID_W] = r_s1_data[i*ID_W +: ID_W];
        end
    end

    // Stage 2 decision: how many beats to push and what stays in the accumulator
    always_comb begin
        w_push_cnt  = 2'd0;
        w_beat0     = '0;
        w_beat1     = '0;
        w_ids       = '0;
        w_h_nxt     = r_h;
        w_acc_nxt   = r_acc;
        w_first_nxt = r_first;
        if (r_s1_valid) begin
            if (!r_s1_eop) begin
                if (w_t >= 4'd8) begin
                    w_push_cnt   = 2'd1;
                    w_beat0.sop  = r_first;
                    w_beat0.data = w_slots[BEAT_W-1:0];
                    w_ids        = 4'd8;
                    w_h_nxt      = w_t[2:0];
                    w_acc_nxt    = w_slots[2*BEAT_W-1:BEAT_W];
                    w_first_nxt  = 1'b0;
                end else begin
                    w_h_nxt   = w_t[2:0];
                    w_acc_nxt = w_slots[BEAT_W-1:0];
                end
            end else begin
                // Packet end: flush everything, splitting across two beats when T > 8
                w_ids        = w_t;
                w_beat0.sop  = r_first;
                w_beat0.data = w_slots[BEAT_W-1:0];
                if (w_t > 4'd8) begin
                    w_push_cnt    = 2'd2;
                    w_beat1.eop   = 1'b1;
                    w_beat1.empty = empty_bytes(w_t - 4'd8);
                    w_beat1.data  = w_slots[2*BEAT_W-1:BEAT_W];
                end else begin
                    w_push_cnt    = 2'd1;
                    w_beat0.eop   = 1'b1;
                    w_beat0.empty = empty_bytes(w_t);
                end
                w_h_nxt     = '0;
                w_acc_nxt   = '0;
                w_first_nxt = 1'b1;
            end
        end
    end

`ifdef RULE_PACKER_DEDUP_EN
    // Track the most recently accumulated ID of the current packet
    always_comb begin
        w_last_nxt = r_last_id;
        if (r_s1_valid) begin
            for (int i = 0; i < PACK_LANES; i++) begin
                if (w_m2[i]) w_last_nxt = r_s1_data[i*ID_W +: ID_W];
            end
            if (r_s1_eop) w_last_nxt = '0;
        end
    end

    // Last-ID register, cleared between packets
    always_ff @(posedge clk) begin
        if (rst) r_last_id <= '0;
        else     r_last_id <= w_last_nxt;
    end
`endif

    // Stage 2 state and push register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_h        <= '0;
            r_first    <= 1'b1;
            r_push_cnt <= '0;
            r_beat0    <= '0;
            r_beat1    <= '0;
            r_push_ids <= '0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_h        <= w_h_nxt;
            r_first    <= w_first_nxt;
            r_push_cnt <= w_push_cnt;
            r_beat0    <= w_beat0;
            r_beat1    <= w_beat1;
            r_push_ids <= w_ids;
        end
    end

    // A cycle's pushes go in together or are dropped together
    assign w_free  = DEPTH_V - w_count;
    assign w_drop  = (r_push_cnt != 2'd0) && ({{(CW-2){1'b0}}, r_push_cnt} > w_free);
    assign w_push0 = (r_push_cnt != 2'd0) && !w_drop;
    assign w_push1 = (r_push_cnt == 2'd2) && !w_drop;

    push2_fifo #(
        .WIDTH (BEAT_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push0 (w_push0),
        .i_data0 (r_beat0),
        .i_push1 (w_push1),
        .i_data1 (r_beat1),
        .i_pop   (out_match_ready),
        .o_valid (out_match_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign out_match_sop   = w_head.sop;
    assign out_match_eop   = w_head.eop;
    assign out_match_empty = w_head.empty;
    assign out_match_data  = w_head.data;

    // Back-pressure flag and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            in_almost_full <= 1'b0;
            rule_cnt       <= '0;
            drop_cnt       <= '0;
        end else begin
            in_almost_full <= (w_count >= AF_LVL);
            if (w_push0) rule_cnt <= rule_cnt + {28'd0, r_push_ids};
            if (w_drop)  drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_rule_packer.sv
// tb/tb_rule_packer.sv - self-checking bench for rule_packer
module tb_rule_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_eop;
    logic [127:0] in_data;
    logic         ready;
    logic         af;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic [127:0] out_data;
    logic [5:0]   out_empty;
    logic [31:0]  rule_cnt;
    logic [31:0]  drop_cnt;

    rule_packer dut (
        .clk             (clk),
        .rst             (rst),
        .in_match_valid  (in_valid),
        .in_match_eop    (in_eop),
        .in_match_data   (in_data),
        .in_almost_full  (af),
        .out_match_valid (out_valid),
        .out_match_ready (ready),
        .out_match_sop   (out_sop),
        .out_match_eop   (out_eop),
        .out_match_data  (out_data),
        .out_match_empty (out_empty),
        .rule_cnt        (rule_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
        int           ids;
    } mbeat_t;

    int     n_checks = 0;
    int     n_errors = 0;

    // Model: packet ID list, beats in flight (3-cycle latency), output FIFO
    int     pend[$];
    mbeat_t grp0[$];
    mbeat_t grp1[$];
    mbeat_t mq[$];
    mbeat_t log_q[$];
    bit     m_first;
    int     m_rule;
    int     m_drop;
    bit     m_af;
    int     m_occ;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic emit();
        mbeat_t b;
        int     k;
        k = (pend.size() >= 8) ? 8 : pend.size();
        b.data = '0;
        for (int j = 0; j < k; j++) b.data[16*j +: 16] = 16'(pend.pop_front());
        b.eop   = in_eop && (pend.size() == 0);
        b.empty = 6'(16 - 2 * k);
        b.sop   = m_first;
        m_first = b.eop;
        b.ids   = k;
        grp0.push_back(b);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            pend.delete(); grp0.delete(); grp1.delete(); mq.delete();
            m_first = 1'b1; m_rule = 0; m_drop = 0; m_af = 1'b0;
        end else begin
            m_occ = mq.size();
            m_af  = (m_occ >= 24);
            if (m_occ > 0 && ready) void'(mq.pop_front());
            if (grp1.size() > 64 - m_occ) m_drop++;
            else foreach (grp1[k]) begin
                mq.push_back(grp1[k]);
                m_rule += grp1[k].ids;
            end
            grp1 = grp0;
            grp0.delete();
            if (in_valid) begin
                for (int i = 0; i < 8; i++)
                    if (in_data[16*i +: 16] != 16'd0) pend.push_back(int'(in_data[16*i +: 16]));
                if (!in_eop) begin
                    if (pend.size() >= 8) emit();
                end else begin
                    do emit(); while (pend.size() > 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        if (out_valid && mq.size() > 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_sop", 128'(out_sop), 128'(mq[0].sop));
            chk("out_eop", 128'(out_eop), 128'(mq[0].eop));
            chk("out_empty", 128'(out_empty), 128'(mq[0].empty));
        end
        chk("almost_full", 128'(af), 128'(m_af));
        chk("rule_cnt", 128'(rule_cnt), 128'(m_rule));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        if (out_valid && ready) begin
            mbeat_t b;
            b.data = out_data; b.sop = out_sop; b.eop = out_eop; b.empty = out_empty; b.ids = 0;
            log_q.push_back(b);
        end
    end

    task automatic send(input logic [127:0] d, input logic e);
        in_valid = 1'b1; in_data = d; in_eop = e;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0; in_eop = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            if (mq.size() == 0 && grp0.size() == 0 && grp1.size() == 0 && !out_valid) done = 1'b1;
        end
        chk({nm, "_drain"}, 128'(done), 128'd1);
    endtask

    task automatic check_beat(input string nm, input int idx, input logic [127:0] d,
                              input logic s, input logic e, input logic [5:0] em);
        if (idx < log_q.size()) begin
            chk({nm, "_data"}, log_q[idx].data, d);
            chk({nm, "_sop"}, 128'(log_q[idx].sop), 128'(s));
            chk({nm, "_eop"}, 128'(log_q[idx].eop), 128'(e));
            chk({nm, "_empty"}, 128'(log_q[idx].empty), 128'(em));
        end else begin
            chk({nm, "_present"}, 128'd0, 128'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_eop = 1'b0; in_data = '0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", 128'(out_valid), 128'd0);
        chk("reset_rule_cnt", 128'(rule_cnt), 128'd0);

        // Single-beat packet and input-to-output latency
        log_q.delete();
        send(pk8(0, 5, 0, 9, 0, 0, 0, 3), 1'b1);
        @(posedge clk); #1;
        chk("latency_2", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        chk("latency_3", 128'(out_valid), 128'd1);
        drain("t1");
        chk("t1_count", 128'(log_q.size()), 128'd1);
        check_beat("t1", 0, pk8(5, 9, 3, 0, 0, 0, 0, 0), 1'b1, 1'b1, 6'd10);
        chk("t1_rule_cnt", 128'(rule_cnt), 128'd3);

        // Two beats, 5 then 6 IDs
        log_q.delete();
        send(pk8(11, 12, 13, 14, 15, 0, 0, 0), 1'b0);
        send(pk8(0, 0, 21, 22, 23, 24, 25, 26), 1'b1);
        drain("t2");
        check_beat("t2a", 0, pk8(11, 12, 13, 14, 15, 21, 22, 23), 1'b1, 1'b0, 6'd0);
        check_beat("t2b", 1, pk8(24, 25, 26, 0, 0, 0, 0, 0), 1'b0, 1'b1, 6'd10);

        // Seven held plus eight on eop: two pushes in one cycle
        log_q.delete();
        send(pk8(31, 32, 33, 34, 35, 36, 37, 0), 1'b0);
        send(pk8(41, 42, 43, 44, 45, 46, 47, 48), 1'b1);
        drain("t3");
        check_beat("t3a", 0, pk8(31, 32, 33, 34, 35, 36, 37, 41), 1'b1, 1'b0, 6'd0);
        check_beat("t3b", 1, pk8(42, 43, 44, 45, 46, 47, 48, 0), 1'b0, 1'b1, 6'd2);

        // Empty eop packet
        log_q.delete();
        send('0, 1'b1);
        drain("t4");
        check_beat("t4", 0, '0, 1'b1, 1'b1, 6'd16);
        chk("t4_rule_cnt", 128'(rule_cnt), 128'd29);

        // Overflow with ready low, then drain in order
        log_q.delete();
        ready = 1'b0;
        for (int k = 0; k < 80; k++)
            send(pk8(1000+8*k, 1001+8*k, 1002+8*k, 1003+8*k, 1004+8*k, 1005+8*k, 1006+8*k, 1007+8*k), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_drop_cnt", 128'(drop_cnt), 128'd16);
        chk("t5_almost_full", 128'(af), 128'd1);
        ready = 1'b1;
        drain("t5");
        chk("t5_count", 128'(log_q.size()), 128'd64);
        check_beat("t5_first", 0, pk8(1000, 1001, 1002, 1003, 1004, 1005, 1006, 1007), 1'b1, 1'b0, 6'd0);
        check_beat("t5_last", 63, pk8(1504, 1505, 1506, 1507, 1508, 1509, 1510, 1511), 1'b0, 1'b0, 6'd0);
        chk("t5_rule_cnt", 128'(rule_cnt), 128'd541);
        log_q.delete();
        send('0, 1'b1);
        drain("t5_close");
        check_beat("t5_close", 0, '0, 1'b0, 1'b1, 6'd16);

        // Reset mid-packet
        log_q.delete();
        send(pk8(51, 52, 53, 0, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_valid", 128'(out_valid), 128'd0);
        chk("t6_rule_cnt", 128'(rule_cnt), 128'd0);
        chk("t6_drop_cnt", 128'(drop_cnt), 128'd0);
        send(pk8(0, 61, 0, 62, 0, 0, 0, 0), 1'b1);
        drain("t6");
        chk("t6_count", 128'(log_q.size()), 128'd1);
        check_beat("t6", 0, pk8(61, 62, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 6'd12);
        chk("t6_rule_cnt_after", 128'(rule_cnt), 128'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
